seq_trigger_mc: RTL and testbench
=================================

Name: seq_trigger_mc

Overview:
- Parametrised multi-channel successor of the single-channel load/done sequence trigger.
- Each channel detects a rising edge of load_mem followed by done within a configurable window [MIN_DLY:MAX_DLY] (first match only), then issues a one-cycle ready pulse.
- Adds per-channel timeout reporting, channel enables, an optional retrigger mode and saturating match counters.
- Sits beside memory-load controllers as a completion/handshake monitor feeding status logic.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- MIN_DLY, 0, earliest cycle offset (relative to rise edge) at which done counts as a match.
- MAX_DLY, 5, last cycle offset at which done counts; MAX_DLY >= MIN_DLY, MAX_DLY <= 255.
- RETRIG, 0, 0 = a new rise while armed is ignored; 1 = a new rise restarts the window.
- CNT_W, 16, width of each per-channel match counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel enable; 0 forces that channel IDLE.
- load_mem  input  NUM_CH  per-channel load request level.
- done  input  NUM_CH  per-channel completion level.
- cnt_clr  input  1  synchronous clear of all match counters.
- ready  output  NUM_CH  one-cycle match pulse, registered.
- timeout  output  NUM_CH  one-cycle window-expired pulse, registered.
- busy  output  NUM_CH  channel is in ARMED.
- any_ready  output  1  registered OR of the next ready vector (same cycle as ready).
- match_cnt  output  NUM_CH*CNT_W  packed saturating match counters, channel 0 in the LSBs.

Behaviour:
- One clock, clk. Reset is synchronous, active-high, named reset. All outputs are registered.
- Reset values: state=IDLE, window counter=0, ready=0, timeout=0, busy=0, any_ready=0, match_cnt=0, prev_load=1. prev_load=1 prevents a spurious rise when load_mem is held high through reset.
- Rise detection: rise = load_mem & ~prev_load, with prev_load updated every cycle regardless of ch_en.
- Offset 0 is the edge on which the rise is sampled.
- FSM per channel has two states: IDLE and ARMED.
- IDLE, on rise & ch_en:
  - If MIN_DLY==0 and done is high on the same edge: match; stay IDLE.
  - Otherwise: go to ARMED with cnt=1.
- ARMED, each edge:
  - If done and cnt>=MIN_DLY: match; go to IDLE.
  - Else if cnt==MAX_DLY: timeout; go to IDLE.
  - Else: cnt++.
- Match or timeout evaluated on edge t drives ready or timeout high from edge t to edge t+1. There is exactly one pulse per attempt.
- First-match semantics: done pulses after a match, or before MIN_DLY, are ignored for that attempt.
- Rise while ARMED:
  - RETRIG=0: ignored.
  - RETRIG=1 without a match on that edge: cnt restarts at 1.
  - RETRIG=1 with a match on the same edge: the match is reported, and the channel re-arms with cnt=1. The done on that edge is consumed by the old attempt.
- Only one attempt per channel is tracked at a time. Overlapping attempts are not counted separately.
- ch_en low: forces IDLE on the next edge, no ready or timeout. Any pending attempt is dropped silently.
- busy is 1 exactly while in ARMED.
- match_cnt[ch] increments on each ready pulse and saturates at 2^CNT_W-1.
- cnt_clr has priority over an increment on the same edge: the result is 0.
- Reset mid-window: the channel returns to IDLE next edge, no pulse.
- Window counter width is clog2(MAX_DLY+1) and never wraps.

Decomposition:
- Package seq_trigger_pkg holds:
  - state enum (IDLE, ARMED);
  - function for window-counter width;
  - parameter legality checks (elaboration-time assertion that MIN_DLY<=MAX_DLY).
- Sub-module seq_trigger_ch contains one channel: edge detect, FSM, window counter and match counter. It is instantiated NUM_CH times in a generate loop.
- The top level holds only the generate loop, packing of match_cnt and the any_ready OR.

Test Plan:
- Defaults, ch0: rise on edge 10, done high on edge 13 -> ready[0]=1 only in the cycle after edge 13, any_ready=1, busy[0]=1 over edges 10..13, match_cnt[0]=1.
- Defaults, ch1: rise on edge 20, done never -> timeout[1] pulse after edge 25, ready[1]=0, match_cnt[1]=0.
- MIN_DLY=2: rise with done already high at offsets 0 and 1, and high again at offset 3 -> single ready at offset 3; done at offset 4 gives no second pulse.
- RETRIG=1: rise at edge 0, new rise at edge 4, done at edge 8 -> ready after edge 8 with no timeout at edge 5. With RETRIG=0 the same stimulus gives timeout at edge 5 and no ready.
- All 4 channels matching on the same edge -> ready=4'hF for one cycle. Drive 70000 matches on ch2 -> match_cnt[2] holds 16'hFFFF. cnt_clr concurrent with a match -> counter reads 0.
- reset asserted at offset 2 of an armed window, and ch_en dropped at offset 3 of another window -> no ready or timeout, busy=0 next cycle. Hold load_mem high through reset release -> no trigger.

Source files
------------

// File: rtl/seq_trigger_pkg.sv
// ---------------------------------------------------------------------------
// seq_trigger_pkg
//   Shared types and elaboration-time helpers for the multi-channel
//   load/done sequence trigger.
//   Contents:
//     chState_e       - per-channel FSM state (IDLE, ARMED)
//     winCntWidth()   - width of the per-channel window counter
//     dlyParamsLegal()- MIN_DLY/MAX_DLY legality check
//     chCountLegal()  - NUM_CH legality check
// ---------------------------------------------------------------------------
package seq_trigger_pkg;

  // IDLE waits for a qualified rise; ARMED counts window offsets.
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chState_e;

  // The window counter has to hold offsets 0..maxDly. It never needs
  // to exceed maxDly, so clog2(maxDly+1) bits are enough. The floor of
  // one bit keeps maxDly == 0 from producing a zero-width vector.
  function automatic int winCntWidth(input int maxDly);
    int w;
    w = $clog2(maxDly + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // The window must be non-empty and fit the 8-bit offset range.
  function automatic bit dlyParamsLegal(input int minDly, input int maxDly);
    return (minDly >= 0) && (minDly <= maxDly) && (maxDly <= 255);
  endfunction

  function automatic bit chCountLegal(input int numCh);
    return (numCh >= 1) && (numCh <= 32);
  endfunction

endpackage

// File: rtl/seq_trigger_ch.sv
// ---------------------------------------------------------------------------
// seq_trigger_ch
//   One channel of the sequence trigger: rising-edge detect on load, the
//   IDLE/ARMED window FSM, the window counter and a saturating match counter.
//   Ports:
//     clk, reset     - clock, synchronous active-high reset
//     en_i           - channel enable; low forces IDLE with no pulse
//     load_i, done_i - load request level / completion level
//     cntClr_i       - synchronous clear of the match counter
//     readyNext_o    - match decision for this edge (unregistered)
//     ready_o        - registered one-cycle match pulse
//     timeout_o      - registered one-cycle window-expired pulse
//     busy_o         - registered, high while ARMED
//     matchCnt_o     - saturating count of ready pulses
// ---------------------------------------------------------------------------
module seq_trigger_ch
  import seq_trigger_pkg::*;
#(
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 5,
  parameter int RETRIG  = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             done_i,
  input  logic             cntClr_i,
  output logic             readyNext_o,
  output logic             ready_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] matchCnt_o
);

  localparam int               WinW        = winCntWidth(MAX_DLY);
  localparam logic [WinW-1:0]  WinOne      = WinW'(1);
  localparam logic [WinW:0]    WinOneWide  = (WinW + 1)'(1);
  localparam logic [WinW:0]    MinDlyWide  = (WinW + 1)'(MIN_DLY);
  localparam logic [WinW:0]    MaxDlyWide  = (WinW + 1)'(MAX_DLY);
  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);
  localparam bit               ImmediateOk = (MIN_DLY == 0);
  localparam bit               RetrigOk    = (RETRIG != 0);

  chState_e         state_q, state_d;
  logic [WinW-1:0]  winCnt_q, winCnt_d;
  logic             prevLoad_q;
  logic             ready_q, timeout_q, busy_q;
  logic [CNT_W-1:0] matchCnt_q;

  logic             rise;
  logic             windowOpen;
  logic             windowLast;
  logic             restart;
  logic             matchNow;
  logic             timeoutNow;

  assign rise = load_i & ~prevLoad_q;

  // Comparisons are done as (cnt + 1) > limit in one extra bit, which
  // equals cnt >= limit without an always-true compare when the limit is 0.
  assign windowOpen = (({1'b0, winCnt_q} + WinOneWide) > MinDlyWide);
  assign windowLast = (({1'b0, winCnt_q} + WinOneWide) > MaxDlyWide);
  assign restart    = RetrigOk && rise;

  // State register plus the edge-detect history. prevLoad resets high so a
  // load held through reset is not mistaken for a fresh request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      winCnt_q   <= '0;
      prevLoad_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      winCnt_q   <= winCnt_d;
      prevLoad_q <= load_i;
    end
  end

  // Next-state logic. A match always wins over a restart or a timeout on
  // the same edge; with retrigger enabled the rise then re-arms at offset 1.
  always_comb begin
    state_d  = state_q;
    winCnt_d = winCnt_q;
    if (!en_i) begin
      state_d  = IDLE;
      winCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && !(ImmediateOk && done_i)) begin
            state_d  = ARMED;
            winCnt_d = WinOne;
          end
        end
        ARMED: begin
          if (done_i && windowOpen) begin
            if (restart) begin
              state_d  = ARMED;
              winCnt_d = WinOne;
            end else begin
              state_d  = IDLE;
              winCnt_d = '0;
            end
          end else if (restart) begin
            winCnt_d = WinOne;
          end else if (windowLast) begin
            state_d  = IDLE;
            winCnt_d = '0;
          end else begin
            winCnt_d = winCnt_q + WinOne;
          end
        end
        default: begin
          state_d  = IDLE;
          winCnt_d = '0;
        end
      endcase
    end
  end

  // Output decode: at most one of match/timeout per edge, none while disabled.
  always_comb begin
    matchNow   = 1'b0;
    timeoutNow = 1'b0;
    if (en_i) begin
      case (state_q)
        IDLE:    matchNow = rise && ImmediateOk && done_i;
        ARMED: begin
          if (done_i && windowOpen) begin
            matchNow = 1'b1;
          end else if (!restart && windowLast) begin
            timeoutNow = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered pulses and status; the match counter saturates and a
  // clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      matchCnt_q <= '0;
    end else begin
      ready_q   <= matchNow;
      timeout_q <= timeoutNow;
      busy_q    <= (state_d == ARMED);
      if (cntClr_i) begin
        matchCnt_q <= '0;
      end else if (matchNow && (matchCnt_q != CntMax)) begin
        matchCnt_q <= matchCnt_q + CntOne;
      end
    end
  end

  assign readyNext_o = matchNow;
  assign ready_o     = ready_q;
  assign timeout_o   = timeout_q;
  assign busy_o      = busy_q;
  assign matchCnt_o  = matchCnt_q;

endmodule

// File: rtl/seq_trigger_mc.sv
// ---------------------------------------------------------------------------
// seq_trigger_mc
//   Multi-channel load/done sequence trigger. Each channel independently
//   reports a one-cycle ready pulse when done follows a load rise inside
//   [MIN_DLY:MAX_DLY], or a timeout pulse when the window expires.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset
//     ch_en       - per-channel enable
//     load_mem    - per-channel load request level
//     done        - per-channel completion level
//     cnt_clr     - clear all match counters
//     ready       - per-channel registered match pulse
//     timeout     - per-channel registered window-expired pulse
//     busy        - per-channel ARMED indication
//     any_ready   - registered OR of ready, aligned with ready
//     match_cnt   - packed saturating match counters, channel 0 in LSBs
// ---------------------------------------------------------------------------
module seq_trigger_mc
  import seq_trigger_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 5,
  parameter int RETRIG  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       load_mem,
  input  logic [NUM_CH-1:0]       done,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       ready,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       busy,
  output logic                    any_ready,
  output logic [NUM_CH*CNT_W-1:0] match_cnt
);

  if (!dlyParamsLegal(MIN_DLY, MAX_DLY)) begin : gBadDly
    $error("seq_trigger_mc: need 0 <= MIN_DLY <= MAX_DLY <= 255");
  end
  if (!chCountLegal(NUM_CH)) begin : gBadNumCh
    $error("seq_trigger_mc: NUM_CH must be within 1..32");
  end

  logic [NUM_CH-1:0] readyNext;
  logic              anyReady_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
    seq_trigger_ch #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY),
      .RETRIG  (RETRIG),
      .CNT_W   (CNT_W)
    ) uCh (
      .clk         (clk),
      .reset       (reset),
      .en_i        (ch_en[ch]),
      .load_i      (load_mem[ch]),
      .done_i      (done[ch]),
      .cntClr_i    (cnt_clr),
      .readyNext_o (readyNext[ch]),
      .ready_o     (ready[ch]),
      .timeout_o   (timeout[ch]),
      .busy_o      (busy[ch]),
      .matchCnt_o  (match_cnt[ch*CNT_W +: CNT_W])
    );
  end

  // OR the next-cycle ready vector so any_ready lines up with ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      anyReady_q <= 1'b0;
    end else begin
      anyReady_q <= |readyNext;
    end
  end

  assign any_ready = anyReady_q;

endmodule

// File: tb/tb_seq_trigger_mc.sv
// ---------------------------------------------------------------------------
// tb_seq_trigger_mc
//   Drives two trigger instances with one shared directed stimulus stream:
//     dutA - defaults (MIN_DLY=0, MAX_DLY=5, RETRIG=0, CNT_W=16)
//     dutB - MIN_DLY=2, MAX_DLY=5, RETRIG=1, CNT_W=4 (small counter so
//            saturation is reachable in a short run)
//   A timestamp-based model of every channel predicts all outputs and is
//   compared each cycle; hand-computed literals pin key moments.
// ---------------------------------------------------------------------------
module tb_seq_trigger_mc;

  logic        clk;
  logic        reset;
  logic        cnt_clr;
  logic [3:0]  ch_en;
  logic [3:0]  load_mem;
  logic [3:0]  done;

  logic [3:0]  readyA, timeoutA, busyA;
  logic        anyA;
  logic [63:0] mcA;
  logic [3:0]  readyB, timeoutB, busyB;
  logic        anyB;
  logic [15:0] mcB;

  int nChecks = 0;
  int nPass   = 0;

  seq_trigger_mc #(
    .NUM_CH(4), .MIN_DLY(0), .MAX_DLY(5), .RETRIG(0), .CNT_W(16)
  ) dutA (
    .clk(clk), .reset(reset), .ch_en(ch_en), .load_mem(load_mem),
    .done(done), .cnt_clr(cnt_clr), .ready(readyA), .timeout(timeoutA),
    .busy(busyA), .any_ready(anyA), .match_cnt(mcA)
  );

  seq_trigger_mc #(
    .NUM_CH(4), .MIN_DLY(2), .MAX_DLY(5), .RETRIG(1), .CNT_W(4)
  ) dutB (
    .clk(clk), .reset(reset), .ch_en(ch_en), .load_mem(load_mem),
    .done(done), .cnt_clr(cnt_clr), .ready(readyB), .timeout(timeoutB),
    .busy(busyB), .any_ready(anyB), .match_cnt(mcB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model parameters per instance: index 0 is dutA, index 1 is dutB.
  int pMin    [2] = '{0, 2};
  int pMax    [2] = '{5, 5};
  int pRetrig [2] = '{0, 1};
  int pSat    [2] = '{65535, 15};

  // Each attempt is remembered by the edge number of its rise; the offset
  // of any later edge is just the difference of edge numbers.
  int   edgeIdx = 0;
  int   mStart  [2][4];
  bit   mActive [2][4];
  bit   mPrev   [2][4];
  int   mCnt    [2][4];
  bit [3:0] eRdy  [2];
  bit [3:0] eTo   [2];
  bit [3:0] eBusy [2];
  bit       eAny  [2];
  bit       modelLive = 1'b0;

  always @(posedge clk) begin
    edgeIdx++;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        bit isRise;
        bit r;
        bit t;
        int off;
        r = 1'b0;
        t = 1'b0;
        if (reset) begin
          mActive[d][c] = 1'b0;
          mPrev[d][c]   = 1'b1;
          mCnt[d][c]    = 0;
        end else begin
          isRise      = load_mem[c] && !mPrev[d][c];
          mPrev[d][c] = load_mem[c];
          if (!ch_en[c]) begin
            mActive[d][c] = 1'b0;
          end else if (mActive[d][c]) begin
            off = edgeIdx - mStart[d][c];
            if (done[c] && off >= pMin[d]) begin
              r = 1'b1;
              mActive[d][c] = 1'b0;
              if (isRise && pRetrig[d] != 0) begin
                mActive[d][c] = 1'b1;
                mStart[d][c]  = edgeIdx;
              end
            end else if (isRise && pRetrig[d] != 0) begin
              mStart[d][c] = edgeIdx;
            end else if (off >= pMax[d]) begin
              t = 1'b1;
              mActive[d][c] = 1'b0;
            end
          end else if (isRise) begin
            if (done[c] && pMin[d] == 0) begin
              r = 1'b1;
            end else begin
              mActive[d][c] = 1'b1;
              mStart[d][c]  = edgeIdx;
            end
          end
          if (cnt_clr) begin
            mCnt[d][c] = 0;
          end else if (r && mCnt[d][c] < pSat[d]) begin
            mCnt[d][c] = mCnt[d][c] + 1;
          end
        end
        eRdy[d][c]  = r;
        eTo[d][c]   = t;
        eBusy[d][c] = mActive[d][c];
      end
      eAny[d] = |eRdy[d];
    end
    modelLive = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare both DUTs to the model.
  logic [63:0] expMcA;
  logic [15:0] expMcB;
  always @(negedge clk) begin
    if (modelLive) begin
      for (int c = 0; c < 4; c++) begin
        expMcA[c*16 +: 16] = 16'(mCnt[0][c]);
        expMcB[c*4 +: 4]   = 4'(mCnt[1][c]);
      end
      checkOutput("modelReadyA",   64'(readyA),   64'(eRdy[0]));
      checkOutput("modelTimeoutA", 64'(timeoutA), 64'(eTo[0]));
      checkOutput("modelBusyA",    64'(busyA),    64'(eBusy[0]));
      checkOutput("modelAnyA",     64'(anyA),     64'(eAny[0]));
      checkOutput("modelCntA",     mcA,           expMcA);
      checkOutput("modelReadyB",   64'(readyB),   64'(eRdy[1]));
      checkOutput("modelTimeoutB", 64'(timeoutB), 64'(eTo[1]));
      checkOutput("modelBusyB",    64'(busyB),    64'(eBusy[1]));
      checkOutput("modelAnyB",     64'(anyB),     64'(eAny[1]));
      checkOutput("modelCntB",     64'(mcB),      64'(expMcB));
    end
  end

  // Drive one vector for the next rising edge and return just after it.
  task automatic applyStimulus(input logic [3:0] en, input logic [3:0] ld,
                               input logic [3:0] dn, input logic clr,
                               input logic rst);
    ch_en    = en;
    load_mem = ld;
    done     = dn;
    cnt_clr  = clr;
    reset    = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with load held high, then release with load still high.
    repeat (3) applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
    checkOutput("rstReadyA", 64'(readyA), 64'h0);
    checkOutput("rstBusyA",  64'(busyA),  64'h0);
    checkOutput("rstAnyA",   64'(anyA),   64'h0);
    checkOutput("rstCntA",   mcA,         64'h0);
    repeat (2) applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    checkOutput("holdBusyA", 64'(busyA), 64'h0);
    checkOutput("holdBusyB", 64'(busyB), 64'h0);
    idle(3);

    // ch0: rise at offset 0, done at offset 3.
    applyStimulus(4'hF, 4'b0001, 4'h0, 1'b0, 1'b0);
    checkOutput("ch0BusyOff0", 64'(busyA), 64'h1);
    idle(2);
    applyStimulus(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("ch0Ready",   64'(readyA),     64'h1);
    checkOutput("ch0Any",     64'(anyA),       64'h1);
    checkOutput("ch0Cnt",     64'(mcA[15:0]),  64'h1);
    checkOutput("ch0BusyEnd", 64'(busyA),      64'h0);
    idle(1);
    checkOutput("ch0ReadyOnce", 64'(readyA), 64'h0);
    idle(6);

    // ch1: rise with no done, timeout after offset 5.
    applyStimulus(4'hF, 4'b0010, 4'h0, 1'b0, 1'b0);
    idle(4);
    checkOutput("ch1NoEarlyTo", 64'(timeoutA), 64'h0);
    idle(1);
    checkOutput("ch1Timeout",  64'(timeoutA), 64'h2);
    checkOutput("ch1NoReady",  64'(readyA),   64'h0);
    idle(1);
    checkOutput("ch1ToOnce",   64'(timeoutA),   64'h0);
    checkOutput("ch1Cnt",      64'(mcA[31:16]), 64'h0);
    idle(4);

    // ch0 with done high at offsets 0,1 then 3,4: dutB matches once at 3.
    applyStimulus(4'hF, 4'b0001, 4'b0001, 1'b0, 1'b0);
    checkOutput("immReadyA", 64'(readyA), 64'h1);
    applyStimulus(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("minEarlyB", 64'(readyB), 64'h0);
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("minReadyB", 64'(readyB), 64'h1);
    applyStimulus(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("minSecondB", 64'(readyB), 64'h0);
    idle(6);

    // ch3 retrigger: rise at e0 and e4, done at e8.
    applyStimulus(4'hF, 4'b1000, 4'h0, 1'b0, 1'b0);
    idle(3);
    applyStimulus(4'hF, 4'b1000, 4'h0, 1'b0, 1'b0);
    idle(1);
    checkOutput("retrigToA",   64'(timeoutA), 64'h8);
    checkOutput("retrigNoToB", 64'(timeoutB), 64'h0);
    checkOutput("retrigBusyB", 64'(busyB),    64'h8);
    idle(2);
    applyStimulus(4'hF, 4'h0, 4'b1000, 1'b0, 1'b0);
    checkOutput("retrigReadyB",   64'(readyB), 64'h8);
    checkOutput("retrigNoReadyA", 64'(readyA), 64'h0);
    idle(6);

    // ch2: match and rise on the same edge re-arms dutB.
    applyStimulus(4'hF, 4'b0100, 4'h0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(4'hF, 4'b0100, 4'b0100, 1'b0, 1'b0);
    checkOutput("rtMatchB", 64'(readyB), 64'h4);
    checkOutput("rtRearmB", 64'(busyB),  64'h4);
    idle(4);
    checkOutput("rtNoToYetB", 64'(timeoutB), 64'h0);
    idle(1);
    checkOutput("rtTimeoutB", 64'(timeoutB), 64'h4);
    idle(3);

    // All channels matching on the same edge.
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
    checkOutput("allReadyA", 64'(readyA), 64'hF);
    checkOutput("allAnyA",   64'(anyA),   64'h1);
    checkOutput("allReadyB", 64'(readyB), 64'hF);
    idle(1);
    checkOutput("allOnceA", 64'(readyA), 64'h0);
    idle(5);

    // Counter clear on the same edge as a match.
    checkOutput("preClrCnt0", 64'(mcA[15:0]), 64'd3);
    applyStimulus(4'hF, 4'b0001, 4'b0001, 1'b1, 1'b0);
    checkOutput("clrReadyA",  64'(readyA),      64'h1);
    checkOutput("clrCnt0",    64'(mcA[15:0]),   64'h0);
    checkOutput("clrCnt1",    64'(mcA[31:16]),  64'h0);
    idle(3);

    // ch_en dropped at offset 3 of a ch1 window.
    applyStimulus(4'hF, 4'b0010, 4'h0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(4'b1101, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("enDropBusyA", 64'(busyA), 64'h0);
    checkOutput("enDropBusyB", 64'(busyB), 64'h0);
    idle(2);
    checkOutput("enDropNoToA", 64'(timeoutA), 64'h0);
    checkOutput("enDropNoToB", 64'(timeoutB), 64'h0);
    idle(4);

    // Reset at offset 2 of a ch0 window, done arriving at offset 3.
    applyStimulus(4'hF, 4'b0001, 4'h0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("midRstBusyA", 64'(busyA), 64'h0);
    checkOutput("midRstCntA",  mcA,        64'h0);
    applyStimulus(4'hF, 4'h0, 4'b0001, 1'b0, 1'b0);
    checkOutput("midRstNoReadyA", 64'(readyA), 64'h0);
    idle(3);

    // 20 matches on ch2: dutB's 4-bit counter saturates, dutA counts them.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'hF, 4'b0100, 4'h0, 1'b0, 1'b0);
      applyStimulus(4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(4'hF, 4'h0, 4'b0100, 1'b0, 1'b0);
    end
    checkOutput("satB", 64'(mcB[11:8]),  64'hF);
    checkOutput("cntA", 64'(mcA[47:32]), 64'd20);
    applyStimulus(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("clrSatB", 64'(mcB[11:8]), 64'h0);
    idle(2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
